// File: rtl/arb_req_queue_pkg.sv
// Shared constants and grant helpers for the arbiter request front end.
//   ARB_PORT_IDX_W         : index width for the default requester count
//   ARB_*_DEFAULT          : default sizing for arb_req_queue
//   arb_onehot_to_idx()    : lowest set bit of a grant vector, as an index
package arb_req_queue_pkg;

  localparam int unsigned ARB_NUM_REQ_DEFAULT    = 4;
  localparam int unsigned ARB_PORT_IDX_W         = $clog2(ARB_NUM_REQ_DEFAULT);
  localparam int unsigned ARB_DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned ARB_FIFO_DEPTH_DEFAULT = 4;

  // Widest grant vector the helper accepts; callers zero-extend into it.
  localparam int unsigned ARB_MAX_REQ   = 32;
  localparam int unsigned ARB_MAX_IDX_W = $clog2(ARB_MAX_REQ);

  // Lowest-index set bit wins, so a malformed multi-hot grant still decodes
  // deterministically.
  function automatic logic [ARB_MAX_IDX_W-1:0] arb_onehot_to_idx(
    input logic [ARB_MAX_REQ-1:0] oh
  );
    logic [ARB_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(ARB_MAX_REQ) - 1; i >= 0; i--) begin
      if (oh[i]) idx = ARB_MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single-in / single-out synchronous FIFO with occupancy count.
//   i_push/i_data : write request (ignored while full, no pass-through)
//   i_pop         : read request (ignored while empty)
//   o_data        : current head entry
//   o_count       : occupancy 0..DEPTH
//   o_full/o_empty: occupancy flags
module arb_req_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH+1)-1:0]    o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rptr];

  // Full-ness is judged on registered count, so a same-cycle pop never frees a slot.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= PTR_W'(r_wptr + 1'b1);
      if (w_pop)  r_rptr <= PTR_W'(r_rptr + 1'b1);
      if (w_push && !w_pop)      r_cnt <= CNT_W'(r_cnt + 1'b1);
      else if (!w_push && w_pop) r_cnt <= CNT_W'(r_cnt - 1'b1);
    end
  end

  // Storage needs no reset: entries are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/arb_req_queue.sv
// Requester-side front end for the round-robin arbiter.
//   enq_valid_i/enq_data_i/enq_ready_o : per-port producer push interface
//   req_bitmap_o                       : per-port non-empty, to the arbiter
//   grant_oh_i                         : one-hot grant from the arbiter
//   update_en_o                        : output stage can accept (priority advance)
//   out_valid_o/out_ready_i            : registered output handshake
//   out_data_o/out_port_o              : output payload and its source port
module arb_req_queue
  import arb_req_queue_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = ARB_NUM_REQ_DEFAULT,
  parameter int unsigned DATA_WIDTH     = ARB_DATA_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH     = ARB_FIFO_DEPTH_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQUESTERS-1:0]            enq_valid_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] enq_data_i,
  output logic [NUM_REQUESTERS-1:0]            enq_ready_o,
  output logic [NUM_REQUESTERS-1:0]            req_bitmap_o,
  input  logic [NUM_REQUESTERS-1:0]            grant_oh_i,
  output logic                                 update_en_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [DATA_WIDTH-1:0]                out_data_o,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    out_port_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQUESTERS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQUESTERS-1:0] w_full;
  logic [NUM_REQUESTERS-1:0] w_empty;
  logic [NUM_REQUESTERS-1:0] w_pop;
  logic [NUM_REQUESTERS-1:0] w_eff_grant;
  logic [DATA_WIDTH-1:0]     w_head [NUM_REQUESTERS];
  logic [CNT_W-1:0]          w_cnt  [NUM_REQUESTERS];
  logic                      w_pop_any;
  logic [IDX_W-1:0]          w_idx;

  logic                      r_out_valid;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [IDX_W-1:0]          r_out_port;

  for (genvar gi = 0; gi < int'(NUM_REQUESTERS); gi++) begin : g_port
    arb_req_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (enq_valid_i[gi]),
      .i_data  (enq_data_i[gi*DATA_WIDTH +: DATA_WIDTH]),
      .i_pop   (w_pop[gi]),
      .o_data  (w_head[gi]),
      .o_count (w_cnt[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi])
    );

    // Flags and count must stay coherent.
    a_cnt_flags : assert property (@(posedge clk) disable iff (!rst_n)
      (w_full[gi] == (w_cnt[gi] == CNT_W'(FIFO_DEPTH))) &&
      (w_empty[gi] == (w_cnt[gi] == '0)));
  end

  assign enq_ready_o  = ~w_full;
  assign req_bitmap_o = ~w_empty;
  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign out_port_o   = r_out_port;

  // Output stage accepts when empty or being drained this cycle.
  assign update_en_o = !r_out_valid || out_ready_i;

  // Grants aimed at empty ports are discarded before decode.
  assign w_eff_grant = grant_oh_i & req_bitmap_o;
  assign w_idx       = IDX_W'(arb_onehot_to_idx(ARB_MAX_REQ'(w_eff_grant)));
  assign w_pop_any   = update_en_o && (|w_eff_grant);

  // Single pop strobe toward the decoded port.
  always_comb begin
    w_pop = '0;
    if (w_pop_any) w_pop[w_idx] = 1'b1;
  end

  // Output register: load on pop, clear on drain-without-refill, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
    end else if (update_en_o) begin
      r_out_valid <= w_pop_any;
      if (w_pop_any) begin
        r_out_data <= w_head[w_idx];
        r_out_port <= w_idx;
      end
    end
  end

  // Arbiter must never issue more than one grant bit.
  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_oh_i));

endmodule
